// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the keypad combination-lock controller.
package code_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    OPEN,
    ERROR,
    LOCKOUT
  } state_e;

  // Width of the shared timer: enough bits to count up to the longest duration minus one.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Button/programming inputs and indicator outputs of the combination lock.
interface code_lock_ctrl_if #(
  parameter int BTN_W    = 4,
  parameter int CODE_LEN = 4
);
  logic [BTN_W-1:0]          btn;
  logic                      prog_en;
  logic [CODE_LEN*BTN_W-1:0] code_in;
  logic                      y;
  logic                      green;
  logic                      red;
  logic                      locked_out;
  logic [3:0]                fail_cnt;

  // Button encoder / programming source side.
  modport master (
    output btn, prog_en, code_in,
    input  y, green, red, locked_out, fail_cnt
  );

  // Lock controller side.
  modport slave (
    input  btn, prog_en, code_in,
    output y, green, red, locked_out, fail_cnt
  );
endinterface

// File: rtl/code_lock_ctrl_btn_entry_det.sv
// Turns the debounced button code into single-cycle digit entry events.
// A held button gives one event; the same digit twice needs a release in between.
module btn_entry_det #(
  parameter int BTN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] btn_i,
  output logic             event_o,
  output logic [BTN_W-1:0] digit_o
);

  logic [BTN_W-1:0] btn_q;

  // Remember last cycle's button code for change detection.
  always_ff @(posedge clk) begin
    if (reset) btn_q <= '0;
    else       btn_q <= btn_i;
  end

  assign event_o = (btn_i != '0) && (btn_i != btn_q);
  assign digit_o = btn_i;

endmodule

// File: rtl/code_lock_ctrl.sv
// Combination-lock FSM: digit comparison, wrong-attempt counting with lockout,
// auto-relock and inter-digit timeout, plus the run-time programmable code.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int BTN_W    = 4,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*BTN_W-1:0] DEFAULT_CODE = 16'h4231,
  parameter int MAX_FAIL = 3,
  parameter int OPEN_CYC = 16,
  parameter int LOCK_CYC = 64,
  parameter int TMO_CYC  = 32
) (
  input logic             clk,
  input logic             reset,
  code_lock_ctrl_if.slave bus
);

  localparam int CW    = CODE_LEN * BTN_W;
  localparam int TMR_W = timer_w(OPEN_CYC, LOCK_CYC, TMO_CYC);
  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CODE_LEN - 1);
  localparam logic [TMR_W-1:0] OPEN_END   = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_END   = TMR_W'(LOCK_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_END    = TMR_W'(TMO_CYC - 1);
  localparam logic [3:0]       MAX_FAIL_V = 4'(MAX_FAIL);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mm_q, mm_d;
  logic [3:0]         fail_q, fail_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]      code_q, code_d;
  logic               y_q, red_q, lo_q;

  logic               evt;
  logic [BTN_W-1:0]   digit;
  logic               cur_bad;
  logic               done;
  logic               bad;
  logic [3:0]         fail_inc;

  btn_entry_det #(.BTN_W(BTN_W)) u_det (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.btn),
    .event_o (evt),
    .digit_o (digit)
  );

  // idx is held at 0 outside ENTRY, so this also compares against digit 0 in IDLE.
  assign cur_bad  = (digit != code_q[int'(idx_q) * BTN_W +: BTN_W]);
  assign fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

  // Next-state logic for the FSM, entry tracking, failure counter, timer and code.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mm_d    = mm_q;
    fail_d  = fail_q;
    code_d  = code_q;
    tmr_d   = tmr_q + 1'b1;
    done    = 1'b0;
    bad     = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (evt) begin
          if (CODE_LEN == 1) begin
            done = 1'b1;
            bad  = cur_bad;
          end else begin
            state_d = ENTRY;
            idx_d   = IDX_W'(1);
            mm_d    = cur_bad;
          end
        end
      end
      ENTRY: begin
        if (evt) begin
          tmr_d = '0;
          if (idx_q == IDX_LAST) begin
            done = 1'b1;
            bad  = mm_q | cur_bad;
          end else begin
            idx_d = idx_q + 1'b1;
            mm_d  = mm_q | cur_bad;
          end
        end else if (tmr_q == TMO_END) begin
          state_d = IDLE;
        end
      end
      OPEN: begin
        if (bus.prog_en) code_d = bus.code_in;
        if (tmr_q == OPEN_END) state_d = IDLE;
      end
      ERROR: begin
        state_d = IDLE;
      end
      LOCKOUT: begin
        if (tmr_q == LOCK_END) begin
          state_d = IDLE;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (done) begin
      if (bad) begin
        fail_d  = fail_inc;
        state_d = (fail_inc >= MAX_FAIL_V) ? LOCKOUT : ERROR;
      end else begin
        fail_d  = '0;
        state_d = OPEN;
      end
    end

    if (state_d != state_q) tmr_d = '0;
    if (state_d != ENTRY) begin
      idx_d = '0;
      mm_d  = 1'b0;
    end
  end

  // State register with outputs decoded from the current state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mm_q    <= 1'b0;
      fail_q  <= '0;
      tmr_q   <= '0;
      code_q  <= DEFAULT_CODE;
      y_q     <= 1'b0;
      red_q   <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      code_q  <= code_d;
      y_q     <= (state_q == OPEN);
      red_q   <= (state_q == ERROR) || (state_q == LOCKOUT);
      lo_q    <= (state_q == LOCKOUT);
    end
  end

  assign bus.y          = y_q;
  assign bus.green      = y_q;
  assign bus.red        = red_q;
  assign bus.locked_out = lo_q;
  assign bus.fail_cnt   = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: default-parameter instance plus a
// 6-digit, 3-bit, single-attempt instance.
module tb_code_lock_ctrl;

  typedef struct {
    bit is_open;
    int start;
    int len;
    bit lockout;
    int fail;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q0[$];
  exp_t q1[$];

  code_lock_ctrl_if #(.BTN_W(4), .CODE_LEN(4)) bus0 ();
  code_lock_ctrl_if #(.BTN_W(3), .CODE_LEN(6)) bus1 ();

  code_lock_ctrl dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  code_lock_ctrl #(
    .BTN_W        (3),
    .CODE_LEN     (6),
    .DEFAULT_CODE ({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}),
    .MAX_FAIL     (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit op, input int len, input bit lo, input int f);
    exp_t e;
    e.is_open = op;
    e.start   = 0;
    e.len     = len;
    e.lockout = lo;
    e.fail    = f;
    return e;
  endfunction

  // Per-instance monitor state: one active output pulse at a time.
  bit m_act[2];
  int m_st[2];
  int m_len[2];
  bit m_open[2];
  bit m_lo0[2];
  bit m_lostd[2];
  bit m_gok[2];
  int m_fail[2];

  task automatic mon_step(input int id, input bit y, input bit g, input bit r,
                          input bit lo, input int f);
    exp_t e;
    if (!m_act[id]) begin
      if (y || r) begin
        m_act[id]   = 1'b1;
        m_st[id]    = cyc;
        m_len[id]   = 1;
        m_open[id]  = y;
        m_lo0[id]   = lo;
        m_lostd[id] = 1'b1;
        m_gok[id]   = (g == y);
        m_fail[id]  = f;
      end
    end else if (m_open[id] ? y : r) begin
      m_len[id]++;
      if (lo != m_lo0[id]) m_lostd[id] = 1'b0;
      if (g != y) m_gok[id] = 1'b0;
    end else begin
      m_act[id] = 1'b0;
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        chk($sformatf("d%0d_unexpected_output_open%0d", id, m_open[id]), 1, 0);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("d%0d_kind_open", id), m_open[id], e.is_open);
        chk($sformatf("d%0d_start_cycle", id), m_st[id], e.start);
        chk($sformatf("d%0d_pulse_len", id), m_len[id], e.len);
        chk($sformatf("d%0d_locked_out", id), m_lo0[id], e.lockout);
        chk($sformatf("d%0d_locked_out_steady", id), m_lostd[id], 1);
        chk($sformatf("d%0d_green_eq_y", id), m_gok[id], 1);
        chk($sformatf("d%0d_fail_cnt", id), m_fail[id], e.fail);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_step(0, bus0.y, bus0.green, bus0.red, bus0.locked_out, int'(bus0.fail_cnt));
      mon_step(1, bus1.y, bus1.green, bus1.red, bus1.locked_out, int'(bus1.fail_cnt));
    end
  end

  // One press: drive digit for 'hold' cycles, release for 'rel' cycles.
  task automatic press0(input int d, input int hold, input int rel, input bit ex, input exp_t e);
    exp_t x;
    @(negedge clk);
    bus0.btn = 4'(d);
    if (ex) begin
      x = e;
      x.start = cyc + 2;
      q0.push_back(x);
    end
    repeat (hold) @(negedge clk);
    bus0.btn = '0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic press1(input int d, input bit ex, input exp_t e);
    exp_t x;
    @(negedge clk);
    bus1.btn = 3'(d);
    if (ex) begin
      x = e;
      x.start = cyc + 2;
      q1.push_back(x);
    end
    repeat (5) @(negedge clk);
    bus1.btn = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic code0(input logic [15:0] c, input bit ex, input exp_t e);
    logic [3:0] d;
    for (int k = 0; k < 4; k++) begin
      d = c[k*4 +: 4];
      press0(int'(d), 5, 4, ex && (k == 3), e);
    end
  endtask

  task automatic code1(input logic [17:0] c, input bit ex, input exp_t e);
    logic [2:0] d;
    for (int k = 0; k < 6; k++) begin
      d = c[k*3 +: 3];
      press1(int'(d), ex && (k == 5), e);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  exp_t NONE;

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    NONE = mk(0, 0, 0, 0);
    bus0.btn = '0;
    bus0.prog_en = 1'b0;
    bus0.code_in = '0;
    bus1.btn = '0;
    bus1.prog_en = 1'b0;
    bus1.code_in = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_d0_y", bus0.y, 0);
    chk("rst_d0_green", bus0.green, 0);
    chk("rst_d0_red", bus0.red, 0);
    chk("rst_d0_locked_out", bus0.locked_out, 0);
    chk("rst_d0_fail_cnt", bus0.fail_cnt, 0);
    chk("rst_d1_y", bus1.y, 0);
    chk("rst_d1_red", bus1.red, 0);

    // Default code 1,3,2,4 opens for 16 cycles.
    code0(16'h4231, 1'b1, mk(1, 16, 0, 0));
    repeat (25) @(negedge clk);

    // 1, held 2, 4: only three events, times out without an error.
    press0(1, 5, 4, 1'b0, NONE);
    press0(2, 10, 4, 1'b0, NONE);
    press0(4, 5, 4, 1'b0, NONE);
    repeat (45) @(negedge clk);
    chk("timeout_fail_cnt", bus0.fail_cnt, 0);
    chk("timeout_red", bus0.red, 0);

    // 1,2,2,4 with releases: wrong code, single-cycle red.
    code0(16'h4221, 1'b1, mk(0, 1, 0, 1));
    repeat (5) @(negedge clk);
    chk("wrong1_fail_cnt", bus0.fail_cnt, 1);

    // Second and third wrong codes: error then lockout.
    code0(16'h4444, 1'b1, mk(0, 1, 0, 2));
    repeat (5) @(negedge clk);
    chk("wrong2_fail_cnt", bus0.fail_cnt, 2);
    code0(16'h1111, 1'b1, mk(0, 64, 1, 3));
    // Correct code during lockout is ignored.
    code0(16'h4231, 1'b0, NONE);
    chk("lockout_still_locked", bus0.locked_out, 1);
    repeat (30) @(negedge clk);
    chk("post_lockout_fail_cnt", bus0.fail_cnt, 0);
    chk("post_lockout_red", bus0.red, 0);
    code0(16'h4231, 1'b1, mk(1, 16, 0, 0));
    repeat (25) @(negedge clk);

    // Program a new code while open.
    code0(16'h4231, 1'b1, mk(1, 16, 0, 0));
    bus0.code_in = 16'h1111;
    bus0.prog_en = 1'b1;
    @(negedge clk);
    bus0.prog_en = 1'b0;
    bus0.code_in = '0;
    repeat (20) @(negedge clk);
    // Programming outside OPEN is ignored.
    bus0.code_in = 16'h3333;
    bus0.prog_en = 1'b1;
    @(negedge clk);
    bus0.prog_en = 1'b0;
    bus0.code_in = '0;
    code0(16'h1111, 1'b1, mk(1, 16, 0, 0));
    repeat (25) @(negedge clk);
    code0(16'h4231, 1'b1, mk(0, 1, 0, 1));
    repeat (5) @(negedge clk);
    chk("prog_wrong_fail_cnt", bus0.fail_cnt, 1);

    // Reset mid-entry restores the default code and clears the count.
    press0(1, 5, 4, 1'b0, NONE);
    press0(3, 5, 4, 1'b0, NONE);
    pulse_reset(2);
    @(negedge clk);
    chk("midrst_fail_cnt", bus0.fail_cnt, 0);
    chk("midrst_y", bus0.y, 0);
    press0(2, 5, 4, 1'b0, NONE);
    press0(4, 5, 4, 1'b0, NONE);
    repeat (40) @(negedge clk);
    chk("midrst_partial_y", bus0.y, 0);
    code0(16'h4231, 1'b1, mk(1, 16, 0, 0));
    repeat (25) @(negedge clk);

    // 6-digit, 3-bit instance: one wrong code locks out, correct code opens.
    code1({3'd7, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, mk(0, 64, 1, 1));
    repeat (70) @(negedge clk);
    chk("d1_post_lockout_fail_cnt", bus1.fail_cnt, 0);
    code1({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, mk(1, 16, 0, 0));
    repeat (25) @(negedge clk);

    chk("d0_pending_expectations", q0.size(), 0);
    chk("d1_pending_expectations", q1.size(), 0);
    chk("d0_pulse_open_at_end", m_act[0], 0);
    chk("d1_pulse_open_at_end", m_act[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Parametrised keypad combination-lock controller, the successor to the fixed 4-digit door system. It accepts a run-time-programmable code of CODE_LEN digits, each BTN_W bits wide, and drives unlock (y), green and red indicators. Beyond the previous generation it adds wrong-attempt counting with timed lockout, an auto-relock timer and an inter-digit entry timeout. It sits between the debounced button encoder and the door actuator/indicator drivers.

## Interface
- BTN_W, 4: width of one digit / button code; value 0 means "no button".
- CODE_LEN, 4: digits per code (2..8).
- DEFAULT_CODE, 16'h4231: code loaded at reset. Digit k is in bits [k*BTN_W +: BTN_W], so the default sequence is 1,3,2,4.
- MAX_FAIL, 3: consecutive wrong codes that trigger lockout (1..15).
- OPEN_CYC, 16: cycles the lock stays open.
- LOCK_CYC, 64: lockout duration in cycles.
- TMO_CYC, 32: maximum idle cycles between digits during entry.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- btn  in  BTN_W  current button code, 0 = released.
- prog_en  in  1  request to load code_in as the new code.
- code_in  in  CODE_LEN*BTN_W  new code.
- y  out  1  unlock command.
- green  out  1  open indicator.
- red  out  1  error/lockout indicator.
- locked_out  out  1  high during LOCKOUT.
- fail_cnt  out  4  consecutive wrong-code count.

## Operation
- Digit entry event: btn != 0 and btn != btn_q, where btn_q is btn registered last cycle (reset 0). To enter the same digit twice in a row, btn must return to 0 between entries. Entry events are ignored in OPEN, ERROR and LOCKOUT.
- States: IDLE, ENTRY, OPEN, ERROR, LOCKOUT.
- IDLE: on an entry event, compare the digit with code digit 0, set mismatch flag accordingly, set idx=1 and go to ENTRY. If CODE_LEN==1, evaluate immediately as in ENTRY.
- ENTRY: on each event, OR any mismatch into the flag and increment idx. The CODE_LEN-th digit completes entry:
  - No mismatch: go to OPEN and clear fail_cnt.
  - Mismatch: increment fail_cnt (saturating at 15). If the new count is >= MAX_FAIL, go to LOCKOUT; otherwise go to ERROR.
- Timeout in ENTRY: TMO_CYC cycles without an event → IDLE. This is not counted as a failure.
- OPEN: lasts OPEN_CYC cycles, then IDLE.
- ERROR: lasts exactly 1 cycle, then IDLE.
- LOCKOUT: lasts LOCK_CYC cycles, then IDLE with fail_cnt cleared.
- Outputs are registered and decoded from the state register:
  - y = green = (state==OPEN).
  - red = (state==ERROR || state==LOCKOUT).
  - locked_out = (state==LOCKOUT).
- Programming: prog_en is honoured only in OPEN. code_in is stored at that edge, and the new code applies to the next entry. In all other states prog_en is ignored.
- Single timer counter, wide enough for max(OPEN_CYC, LOCK_CYC, TMO_CYC). It is cleared on every state change and on every accepted digit.

## Timing
- Reset values: state IDLE, y/green/red/locked_out 0, fail_cnt 0, code = DEFAULT_CODE, btn_q 0, idx 0, timer 0.
- Latency: the final correct digit is sampled at edge N; y is high from edge N+1 for exactly OPEN_CYC cycles.
- Wrong final digit: red is high for 1 cycle starting at edge N+1, or for LOCK_CYC cycles if lockout triggers.
- Timeout: entry aborts at the edge where timer reaches TMO_CYC-1 with no event in that cycle. An event in the same cycle wins over the timeout.
- A held button produces one event only.
- An event on the same edge that OPEN, ERROR or LOCKOUT ends is ignored. Entry restarts only from the next change while in IDLE.
- Reset mid-operation: everything returns to reset values, including the code register.

## Structure
- Package code_lock_pkg holds the state enum (IDLE, ENTRY, OPEN, ERROR, LOCKOUT) and the timer-width function (clog2 of the maximum duration).
- Sub-module btn_entry_det(clk, reset, btn, event, digit) contains btn_q and the change detection.
- The top module holds the FSM, idx, mismatch flag, fail_cnt, timer and code register.

## Test plan
- Defaults: reset, then btn 1,3,2,4, one per 10 cycles → y=green=1 for 16 cycles starting the cycle after the '4'; fail_cnt=0.
- Wrong code: btn 1,2,2,4 with no 0 between the two 2s → only 3 events, no completion; after 32 idle cycles → IDLE, red never asserts. Repeat with 0 between the 2s → red pulses for 1 cycle, fail_cnt=1.
- Lockout: three wrong 4-digit codes → locked_out=red=1 for 64 cycles. A correct code entered during lockout is ignored. After lockout fail_cnt=0, and a correct code then opens.
- Program: open, assert prog_en with code_in=16'h1111 → subsequent 1,0,1,0,1,0,1 opens and 1,3,2,4 fails.
- Reset mid-entry: after 1,3, pulse reset → state IDLE, code back to 16'h4231, and 2,4 alone does not open.
- Parameter sweep: CODE_LEN=6, BTN_W=3, MAX_FAIL=1 → a single wrong code locks out; a correct 6-digit code opens.
